// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
//   CNT_W_DEF       : default counter/divisor width
//   DEFAULT_DIV_DEF : default half-period divisor applied at reset
//   chan_idx_w()    : width of the channel-select field for n channels
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF       = 32'd18;
    localparam int unsigned DEFAULT_DIV_DEF = 32'd208333;

    // A single-channel bank still needs a 1-bit select port.
    function automatic int unsigned chan_idx_w(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = unsigned'($clog2(n));
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active and shadow divisor,
// pending flag, registered divided clock and rising-edge tick.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   en           : run enable (level); low holds the channel at phase 0
//   sync         : one-cycle restart strobe shared by all channels
//   wr_en        : shadow divisor write for this channel
//   wr_data      : new half-period divisor
//   out_clk      : divided clock (registered)
//   tick         : one-cycle pulse on each out_clk 0->1 (registered)
//   pending      : shadow divisor waiting to become active
module clk_div_channel #(
    parameter int unsigned CNT_W       = 32'd18,
    parameter int unsigned DEFAULT_DIV = 32'd208333
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    output logic             out_clk,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_r, div_r, shd_r;
    logic             pend_r, out_r, tick_r;

    logic [CNT_W-1:0] cnt_nxt_s, div_nxt_s, shd_nxt_s;
    logic             pend_nxt_s, out_nxt_s, tick_nxt_s;
    logic             restart_s, boundary_s, apply_s;

    // Next-state logic: restart/boundary/count, then shadow apply, then write.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        div_nxt_s  = div_r;
        shd_nxt_s  = shd_r;
        pend_nxt_s = pend_r;
        out_nxt_s  = out_r;
        tick_nxt_s = 1'b0;
        apply_s    = 1'b0;

        // A zero divisor freezes the channel; div_r-1 wrap is irrelevant then.
        restart_s  = sync | ~en | (div_r == ZERO);
        boundary_s = (cnt_r == (div_r - ONE));

        if (restart_s) begin
            cnt_nxt_s = ZERO;
            out_nxt_s = 1'b0;
            apply_s   = pend_r;
        end else if (boundary_s) begin
            cnt_nxt_s  = ZERO;
            out_nxt_s  = ~out_r;
            tick_nxt_s = ~out_r;
            apply_s    = pend_r;
        end else begin
            cnt_nxt_s = cnt_r + ONE;
        end

        // Divisor only changes when the counter restarts, so no short half-period.
        if (apply_s) begin
            div_nxt_s  = shd_r;
            pend_nxt_s = 1'b0;
        end else begin
            div_nxt_s = div_r;
        end

        // A write in the same cycle as an apply lands in the shadow and stays pending.
        if (wr_en) begin
            shd_nxt_s  = wr_data;
            pend_nxt_s = 1'b1;
        end else begin
            shd_nxt_s = shd_r;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= ZERO;
            div_r  <= DIV_RST;
            shd_r  <= DIV_RST;
            pend_r <= 1'b0;
            out_r  <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            div_r  <= div_nxt_s;
            shd_r  <= shd_nxt_s;
            pend_r <= pend_nxt_s;
            out_r  <= out_nxt_s;
            tick_r <= tick_nxt_s;
        end
    end

    assign out_clk = out_r;
    assign tick    = tick_r;
    assign pending = pend_r;

endmodule

// File: rtl/clk_divider_bank.sv
// Multi-channel clock divider: NUM_CH independent divided clocks from clk,
// each with a runtime-programmable half-period divisor.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   en           : per-channel run enable
//   sync         : restart all channels in phase
//   wr_en        : divisor write strobe
//   wr_chan      : channel addressed by the write (out-of-range ignored)
//   wr_data      : new half-period divisor
//   out_clk      : divided clocks
//   tick         : one-cycle pulse per out_clk rising edge
//   pending      : shadow divisor written but not yet active
module clk_divider_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH      = 32'd4,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             en,
    input  logic                          sync,
    input  logic                          wr_en,
    input  logic [chan_idx_w(NUM_CH)-1:0] wr_chan,
    input  logic [CNT_W-1:0]              wr_data,
    output logic [NUM_CH-1:0]             out_clk,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             pending
);

    localparam int unsigned IDX_W = chan_idx_w(NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic wr_hit_s;

        // Only indices below NUM_CH are generated, so out-of-range selects hit nothing.
        assign wr_hit_s = wr_en & (wr_chan == IDX_W'(g));

        clk_div_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (en[g]),
            .sync   (sync),
            .wr_en  (wr_hit_s),
            .wr_data(wr_data),
            .out_clk(out_clk[g]),
            .tick   (tick[g]),
            .pending(pending[g])
        );
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
module tb_clk_divider_bank;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] en = 2'b00;
    logic       sync = 1'b0;
    logic       wr_en = 1'b0;
    logic [0:0] wr_chan = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic [1:0] out_clk, tick, pending;

    logic [2:0] en_b = 3'b111;
    logic       sync_b = 1'b0;
    logic       wr_en_b = 1'b0;
    logic [1:0] wr_chan_b = 2'd0;
    logic [7:0] wr_data_b = 8'd0;
    logic [2:0] out_clk_b, tick_b, pending_b;

    always #5 clk = ~clk;

    clk_divider_bank #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(3)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sync(sync), .wr_en(wr_en),
        .wr_chan(wr_chan), .wr_data(wr_data),
        .out_clk(out_clk), .tick(tick), .pending(pending)
    );

    clk_divider_bank #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .sync(sync_b), .wr_en(wr_en_b),
        .wr_chan(wr_chan_b), .wr_data(wr_data_b),
        .out_clk(out_clk_b), .tick(tick_b), .pending(pending_b)
    );

    typedef struct packed {
        logic [1:0] oc;
        logic [1:0] tk;
        logic [1:0] pd;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;

    int m_cnt[2];
    int m_div[2];
    int m_shd[2];
    bit m_pend[2];
    bit m_out[2];
    bit m_tick[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = 0; m_div[c] = 3; m_shd[c] = 3;
            m_pend[c] = 1'b0; m_out[c] = 1'b0; m_tick[c] = 1'b0;
        end
        sb.delete();
    endtask

    // Advance the reference model by one clock using the currently driven inputs.
    task automatic model_step();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            bit restart;
            bit wr;
            restart = sync || !en[c] || (m_div[c] == 0);
            wr = wr_en && (int'(wr_chan) == c);
            m_tick[c] = 1'b0;
            if (restart) begin
                m_cnt[c] = 0;
                m_out[c] = 1'b0;
                if (m_pend[c]) begin m_div[c] = m_shd[c]; m_pend[c] = 1'b0; end
            end else if (m_cnt[c] == m_div[c] - 1) begin
                m_cnt[c] = 0;
                m_out[c] = !m_out[c];
                m_tick[c] = m_out[c];
                if (m_pend[c]) begin m_div[c] = m_shd[c]; m_pend[c] = 1'b0; end
            end else begin
                m_cnt[c] = m_cnt[c] + 1;
            end
            if (wr) begin m_shd[c] = int'(wr_data); m_pend[c] = 1'b1; end
            e.oc[c] = m_out[c];
            e.tk[c] = m_tick[c];
            e.pd[c] = m_pend[c];
        end
        sb.push_back(e);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; en = 2'b00; sync = 1'b0; wr_en = 1'b0;
        wr_chan = 1'b0; wr_data = 8'd0; wr_en_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        exp_t e, g;
        reset_n = 1'b0; en = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_assert++;
        if ({out_clk, tick, pending} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state got %b required 000000", {out_clk, tick, pending});
        end
        model_reset();
        reset_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            e = sb.pop_front(); g = '{out_clk, tick, pending};
            n_assert++;
            if (g !== e) begin n_fail++; $display("FAIL sb_reset cyc=%0d got %b required %b", cyc, g, e); end
            n_assert++;
            if (tick !== ((cyc == 3 || cyc == 9 || cyc == 15) ? 2'b11 : 2'b00)) begin
                n_fail++; $display("FAIL tick_sched cyc=%0d got %b", cyc, tick);
            end
        end
    endtask

    task automatic test_write_mid();
        exp_t e, g;
        do_reset(); en = 2'b11;
        for (int k = 0; k < 17; k++) begin
            wr_en = (cyc == 4); wr_chan = 1'b0; wr_data = 8'd5;
            step(); wr_en = 1'b0;
            e = sb.pop_front(); g = '{out_clk, tick, pending};
            n_assert++;
            if (g !== e) begin n_fail++; $display("FAIL sb_write_mid cyc=%0d got %b required %b", cyc, g, e); end
            if (cyc == 5) begin
                n_assert++;
                if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL pend_set cyc=%0d got %b required 1", cyc, pending[0]); end
            end
            if (cyc == 6) begin
                n_assert++;
                if ({pending[0], out_clk[0]} !== 2'b00) begin
                    n_fail++; $display("FAIL pend_clear_old_half cyc=%0d got %b required 00", cyc, {pending[0], out_clk[0]});
                end
            end
            if (cyc >= 7) begin
                n_assert++;
                if (tick[0] !== (cyc == 11)) begin n_fail++; $display("FAIL new_div_rise cyc=%0d got %b", cyc, tick[0]); end
            end
        end
    endtask

    task automatic test_div1();
        exp_t e, g;
        do_reset(); en = 2'b11;
        for (int k = 0; k < 13; k++) begin
            wr_en = (cyc == 0); wr_chan = 1'b1; wr_data = 8'd1;
            step(); wr_en = 1'b0;
            e = sb.pop_front(); g = '{out_clk, tick, pending};
            n_assert++;
            if (g !== e) begin n_fail++; $display("FAIL sb_div1 cyc=%0d got %b required %b", cyc, g, e); end
            if (cyc >= 4) begin
                n_assert++;
                if ({out_clk[1], tick[1]} !== {2{cyc % 2 == 1}}) begin
                    n_fail++; $display("FAIL div1_toggle cyc=%0d got %b", cyc, {out_clk[1], tick[1]});
                end
            end
        end
    endtask

    task automatic test_zero_div();
        exp_t e, g;
        do_reset(); en = 2'b11;
        for (int k = 0; k < 15; k++) begin
            wr_en = (cyc == 0) || (cyc == 8); wr_chan = 1'b0;
            wr_data = (cyc == 0) ? 8'd0 : 8'd4;
            step(); wr_en = 1'b0;
            e = sb.pop_front(); g = '{out_clk, tick, pending};
            n_assert++;
            if (g !== e) begin n_fail++; $display("FAIL sb_zero_div cyc=%0d got %b required %b", cyc, g, e); end
            if (cyc == 9 || cyc == 10) begin
                n_assert++;
                if (pending[0] !== (cyc == 9)) begin n_fail++; $display("FAIL zero_pend cyc=%0d got %b", cyc, pending[0]); end
            end
            if (cyc >= 4 && cyc <= 13) begin
                n_assert++;
                if (out_clk[0] !== 1'b0) begin n_fail++; $display("FAIL zero_hold cyc=%0d got %b required 0", cyc, out_clk[0]); end
            end
            if (cyc >= 4) begin
                n_assert++;
                if (tick[0] !== (cyc == 14)) begin n_fail++; $display("FAIL zero_resume cyc=%0d got %b", cyc, tick[0]); end
            end
        end
    endtask

    task automatic test_sync();
        exp_t e, g;
        do_reset(); en = 2'b11;
        for (int k = 0; k < 26; k++) begin
            wr_en = (cyc == 0) || (cyc == 20);
            wr_chan = (cyc == 0) ? 1'b1 : 1'b0;
            wr_data = (cyc == 0) ? 8'd4 : 8'd3;
            sync = (cyc == 20);
            step(); wr_en = 1'b0; sync = 1'b0;
            e = sb.pop_front(); g = '{out_clk, tick, pending};
            n_assert++;
            if (g !== e) begin n_fail++; $display("FAIL sb_sync cyc=%0d got %b required %b", cyc, g, e); end
            if (cyc == 21) begin
                n_assert++;
                if ({out_clk, pending} !== 4'b0001) begin
                    n_fail++; $display("FAIL sync_restart cyc=%0d got %b required 0001", cyc, {out_clk, pending});
                end
            end
            if (cyc >= 22) begin
                n_assert++;
                if (tick !== {(cyc == 25), (cyc == 24)}) begin n_fail++; $display("FAIL sync_phase cyc=%0d got %b", cyc, tick); end
            end
        end
    endtask

    task automatic test_en_drop_reset();
        exp_t e, g;
        do_reset(); en = 2'b11;
        for (int k = 0; k < 14; k++) begin
            wr_en = (cyc == 0); wr_chan = 1'b0; wr_data = 8'd5;
            en = (cyc >= 4 && cyc < 8) ? 2'b01 : 2'b11;
            step(); wr_en = 1'b0;
            e = sb.pop_front(); g = '{out_clk, tick, pending};
            n_assert++;
            if (g !== e) begin n_fail++; $display("FAIL sb_en_drop cyc=%0d got %b required %b", cyc, g, e); end
            if (cyc == 5) begin
                n_assert++;
                if (out_clk[1] !== 1'b0) begin n_fail++; $display("FAIL en_drop got %b required 0", out_clk[1]); end
            end
        end
        // ch0 is mid high-phase here; the reset must clear outputs without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        n_assert++;
        if ({out_clk, tick, pending} !== 6'b0) begin
            n_fail++; $display("FAIL async_reset got %b required 000000", {out_clk, tick, pending});
        end
        en = 2'b11;
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            e = sb.pop_front(); g = '{out_clk, tick, pending};
            n_assert++;
            if (g !== e) begin n_fail++; $display("FAIL sb_post_reset cyc=%0d got %b required %b", cyc, g, e); end
            if (cyc == 3) begin
                n_assert++;
                if (tick !== 2'b11) begin n_fail++; $display("FAIL default_div_restored got %b required 11", tick); end
            end
        end
    endtask

    task automatic test_chan_oob();
        exp_t e, g;
        do_reset(); en = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wr_en_b = (cyc == 0) || (cyc == 4);
            wr_chan_b = (cyc == 0) ? 2'd3 : 2'd2;
            wr_data_b = (cyc == 0) ? 8'd1 : 8'd3;
            step(); wr_en_b = 1'b0;
            e = sb.pop_front(); g = '{out_clk, tick, pending};
            n_assert++;
            if (g !== e) begin n_fail++; $display("FAIL sb_oob cyc=%0d got %b required %b", cyc, g, e); end
            if (cyc == 1 || cyc == 2) begin
                n_assert++;
                if (pending_b !== 3'b000) begin n_fail++; $display("FAIL oob_pending cyc=%0d got %b required 000", cyc, pending_b); end
            end
            if (cyc == 3) begin
                n_assert++;
                if ({out_clk_b, tick_b} !== 6'b111111) begin
                    n_fail++; $display("FAIL oob_rise got %b required 111111", {out_clk_b, tick_b});
                end
            end
            if (cyc == 4) begin
                n_assert++;
                if (out_clk_b !== 3'b111) begin n_fail++; $display("FAIL oob_div_kept got %b required 111", out_clk_b); end
            end
            if (cyc == 5) begin
                n_assert++;
                if (pending_b !== 3'b100) begin n_fail++; $display("FAIL inrange_pending got %b required 100", pending_b); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_mid();
        test_div1();
        test_zero_div();
        test_sync();
        test_en_drop_reset();
        test_chan_oob();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
